// File: rtl/ram_arbiter_pkg.sv
// Shared state encodings and master ids for the dual-master RAM arbiter.
// Clear FSM is enabled with the RAM_ARB_CLEAR_EN macro.
package ram_arbiter_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  localparam logic M0_ID = 1'b0;
  localparam logic M1_ID = 1'b1;

endpackage

// File: rtl/ram_arbiter_if.sv
// Single-beat request/grant channel between one master and the arbiter.
// Read data returns with rvalid one cycle after a read grant.
interface ram_arbiter_if #(
  parameter int DW = 8,
  parameter int AW = 10
);

  logic          req;
  logic          we;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          gnt;
  logic          rvalid;
  logic [DW-1:0] rdata;

  modport master (
    output req, we, addr, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, wdata,
    output gnt, rvalid, rdata
  );

endinterface

// File: rtl/ram_arbiter_rr_arb2.sv
// Two-way round-robin arbiter; ties go to the master not granted last.
// Pointer advances only when upd is high and a request is present.
module ram_arbiter_rr_arb2
  import ram_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       upd,
  output logic [1:0] gnt
);

  logic last;

  always_comb begin
    gnt = req;
    unique case (1'b1)
      (&req):  gnt = (last == M1_ID) ? 2'b01 : 2'b10;
      default: gnt = req;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last <= M1_ID;
    end else if (upd && |req) begin
      last <= gnt[1];
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Two-master controller for a single-port sync-read BRAM with optional
// zero-fill sweep (define RAM_ARB_CLEAR_EN to build the clear FSM).
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int DW = 8,
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  ram_arbiter_if.slave  m0,
  ram_arbiter_if.slave  m1,
  input  logic          clr_start,
  output logic          clr_busy,
  output logic          clr_done,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout
);

  logic          en;
  logic          clearing;
  logic [AW-1:0] cnt;
  logic [1:0]    arb_gnt;
  logic [1:0]    gnt;
  logic          rv0;
  logic          rv1;

`ifdef RAM_ARB_CLEAR_EN
  state_t state;

  // Masters wait out the start, sweep and done cycles.
  assign en = rst_n && (state == ST_IDLE)
           && !clr_start && !clr_done;
  assign clearing = rst_n && (state == ST_CLEAR);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      clr_busy <= 1'b0;
      clr_done <= 1'b0;
    end else begin
      clr_done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (clr_start) begin
            state    <= ST_CLEAR;
            cnt      <= '0;
            clr_busy <= 1'b1;
          end
        end
        ST_CLEAR: begin
          cnt <= cnt + AW'(1);
          if (&cnt) begin
            state    <= ST_IDLE;
            clr_busy <= 1'b0;
            clr_done <= 1'b1;
          end
        end
      endcase
    end
  end
`else
  logic unused_clr;

  assign unused_clr = clr_start;
  assign en         = rst_n;
  assign clearing   = 1'b0;
  assign cnt        = '0;
  assign clr_busy   = 1'b0;
  assign clr_done   = 1'b0;
`endif

  ram_arbiter_rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   ({m1.req, m0.req}),
    .upd   (en),
    .gnt   (arb_gnt)
  );

  assign gnt    = arb_gnt & {2{en}};
  assign m0.gnt = gnt[0];
  assign m1.gnt = gnt[1];

  always_comb begin
    ram_we   = 1'b0;
    ram_addr = '0;
    ram_din  = '0;
    unique case (1'b1)
      clearing: begin
        ram_we   = 1'b1;
        ram_addr = cnt;
      end
      gnt[0]: begin
        ram_we   = m0.we;
        ram_addr = m0.addr;
        ram_din  = m0.wdata;
      end
      gnt[1]: begin
        ram_we   = m1.we;
        ram_addr = m1.addr;
        ram_din  = m1.wdata;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rv0 <= 1'b0;
      rv1 <= 1'b0;
    end else begin
      rv0 <= gnt[0] & ~m0.we;
      rv1 <= gnt[1] & ~m1.we;
    end
  end

  assign m0.rvalid = rv0;
  assign m1.rvalid = rv1;
  assign m0.rdata  = ram_dout;
  assign m1.rdata  = ram_dout;

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter beside a behavioural sync-read RAM.
// Clear scenarios are compiled when RAM_ARB_CLEAR_EN is defined.
module tb_ram_arbiter;

  localparam int DW = 8;
  localparam int AW = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ram_arbiter_if #(.DW(DW), .AW(AW)) m0_if ();
  ram_arbiter_if #(.DW(DW), .AW(AW)) m1_if ();

  logic          clr_start;
  logic          clr_busy;
  logic          clr_done;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout;

  ram_arbiter #(.DW(DW), .AW(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .m0        (m0_if),
    .m1        (m1_if),
    .clr_start (clr_start),
    .clr_busy  (clr_busy),
    .clr_done  (clr_done),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_din   (ram_din),
    .ram_dout  (ram_dout)
  );

  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  int n_run = 0;
  int n_fail = 0;
  int gq[$];
  logic [DW-1:0] rq0[$];
  logic [DW-1:0] rq1[$];
  int exp_busy = 1 << AW;
  int busy_cnt = 0;
  logic pr0 = 1'b0;
  logic pr1 = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic miss(input string nm);
    n_run++;
    n_fail++;
    $display("FAIL %s: event with no expectation pending", nm);
  endtask

  // Monitor: pops expected grants and read data as the DUT presents them.
  always @(negedge clk) begin
    if (!rst_n) begin
      pr0 = 1'b0;
      pr1 = 1'b0;
      busy_cnt = 0;
    end else begin
      if (pr0 || m0_if.rvalid) chk("m0_rvalid_timing", m0_if.rvalid, pr0);
      if (pr1 || m1_if.rvalid) chk("m1_rvalid_timing", m1_if.rvalid, pr1);
      if (m0_if.rvalid) begin
        if (rq0.size() == 0) miss("m0_rdata");
        else chk("m0_rdata", m0_if.rdata, rq0.pop_front());
      end
      if (m1_if.rvalid) begin
        if (rq1.size() == 0) miss("m1_rdata");
        else chk("m1_rdata", m1_if.rdata, rq1.pop_front());
      end
      if (m0_if.gnt || m1_if.gnt) begin
        chk("gnt_onehot", m0_if.gnt & m1_if.gnt, 0);
        if (gq.size() == 0) miss("gnt_winner");
        else chk("gnt_winner", m1_if.gnt, gq.pop_front());
      end
      if (clr_busy) begin
        busy_cnt++;
        chk("gnt_in_clear", m0_if.gnt | m1_if.gnt, 0);
      end
      if (clr_done) begin
        chk("clr_busy_cycles", busy_cnt, exp_busy);
        busy_cnt = 0;
      end
      pr0 = m0_if.gnt && !m0_if.we;
      pr1 = m1_if.gnt && !m1_if.we;
    end
  end

  task automatic drive(input int m, input logic rq, input logic we,
                       input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (m == 0) begin
      m0_if.req = rq; m0_if.we = we; m0_if.addr = a; m0_if.wdata = d;
    end else begin
      m1_if.req = rq; m1_if.we = we; m1_if.addr = a; m1_if.wdata = d;
    end
  endtask

  // For reads, d is the expected read data.
  task automatic op(input int m, input logic we, input logic [AW-1:0] a,
                    input logic [DW-1:0] d, output int waits);
    logic g;
    waits = 0;
    if (!we) begin
      if (m == 0) rq0.push_back(d);
      else rq1.push_back(d);
    end
    drive(m, 1'b1, we, a, d);
    forever begin
      @(negedge clk);
      g = (m == 0) ? m0_if.gnt : m1_if.gnt;
      @(posedge clk); #1;
      if (g) break;
      waits++;
      if (waits > 3000) begin
        miss("gnt_timeout");
        break;
      end
    end
    drive(m, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    drive(0, 1'b1, 1'b1, 10'h005, 8'h5A);
    drive(1, 1'b1, 1'b1, 10'h006, 8'h5A);
    @(negedge clk);
    chk("rst_gnt", {m1_if.gnt, m0_if.gnt}, 0);
    chk("rst_ram_we", ram_we, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    drive(0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    chk("rst_rvalid", {m1_if.rvalid, m0_if.rvalid}, 0);
    chk("rst_clr_busy", clr_busy, 0);
    chk("rst_clr_done", clr_done, 0);
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    clr_start = 1'b0;
    drive(0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0);
    do_reset();

    // 1: write then read on M0
    gq.push_back(0); gq.push_back(0);
    op(0, 1'b1, 10'h005, 8'hA5, w);
    chk("t1_wr_wait", w, 0);
    op(0, 1'b0, 10'h005, 8'hA5, w);
    chk("t1_rd_wait", w, 0);
    idle(3);

    // 2: both masters reading continuously after reset alternate
    do_reset();
    repeat (3) begin gq.push_back(0); gq.push_back(1); end
    fork
      begin
        int a0, a1, a2;
        op(0, 1'b0, 10'h005, 8'hA5, a0);
        op(0, 1'b0, 10'h005, 8'hA5, a1);
        op(0, 1'b0, 10'h005, 8'hA5, a2);
        chk("t2_m0_waits", {8'(a0), 8'(a1), 8'(a2)}, 32'h00_01_01);
      end
      begin
        int b0, b1, b2;
        op(1, 1'b0, 10'h005, 8'hA5, b0);
        op(1, 1'b0, 10'h005, 8'hA5, b1);
        op(1, 1'b0, 10'h005, 8'hA5, b2);
        chk("t2_m1_waits", {8'(b0), 8'(b1), 8'(b2)}, 32'h01_01_01);
      end
    join
    idle(3);

    // 3: M0 write and M1 read of the same address collide
    gq.push_back(0); gq.push_back(1);
    fork
      begin
        int a0;
        op(0, 1'b1, 10'h3FF, 8'h11, a0);
        chk("t3_m0_wait", a0, 0);
      end
      begin
        int b0;
        op(1, 1'b0, 10'h3FF, 8'h11, b0);
        chk("t3_m1_wait", b0, 1);
      end
    join
    idle(3);

`ifdef RAM_ARB_CLEAR_EN
    // 4: full clear with M0 waiting
    repeat (3) gq.push_back(0);
    op(0, 1'b1, 10'h000, 8'hFF, w);
    op(0, 1'b1, 10'h200, 8'hFF, w);
    op(0, 1'b1, 10'h3FF, 8'hFF, w);
    idle(2);
    exp_busy = 1 << AW;
    gq.push_back(0);
    fork
      begin
        clr_start = 1'b1;
        @(posedge clk); #1;
        clr_start = 1'b0;
      end
      begin
        int a0;
        op(0, 1'b0, 10'h000, 8'h00, a0);
        chk("t4_gnt_after_done", a0 > (1 << AW), 1);
      end
    join
    gq.push_back(0); gq.push_back(0);
    op(0, 1'b0, 10'h200, 8'h00, w);
    op(0, 1'b0, 10'h3FF, 8'h00, w);
    idle(3);

    // 5: reset in the middle of a clear
    gq.push_back(0); gq.push_back(0);
    op(0, 1'b1, 10'h000, 8'hFF, w);
    op(0, 1'b1, 10'h3FF, 8'hFF, w);
    idle(2);
    clr_start = 1'b1;
    @(posedge clk); #1;
    clr_start = 1'b0;
    repeat (98) @(posedge clk);
    @(negedge clk);
    chk("t5_busy_before_rst", clr_busy, 1);
    do_reset();
    chk("t5_busy_after_rst", clr_busy, 0);
    gq.push_back(0); gq.push_back(1);
    fork
      begin
        int a0;
        op(0, 1'b0, 10'h3FF, 8'hFF, a0);
        chk("t5_m0_wait", a0, 0);
      end
      begin
        int b0;
        op(1, 1'b0, 10'h3FF, 8'hFF, b0);
        chk("t5_m1_wait", b0, 1);
      end
    join
    gq.push_back(0);
    op(0, 1'b0, 10'h000, 8'h00, w);
    idle(3);
`else
    // 6: clr_start has no effect without the clear feature
    gq.push_back(1);
    fork
      begin
        clr_start = 1'b1;
        @(negedge clk);
        chk("t6_busy", clr_busy, 0);
        chk("t6_done", clr_done, 0);
        @(posedge clk); #1;
        clr_start = 1'b0;
        repeat (3) begin
          @(negedge clk);
          chk("t6_busy_after", clr_busy, 0);
          chk("t6_done_after", clr_done, 0);
        end
      end
      begin
        int b0;
        op(1, 1'b0, 10'h005, 8'hA5, b0);
        chk("t6_m1_wait", b0, 0);
      end
    join
    idle(3);
`endif

    chk("queues_empty", gq.size() + rq0.size() + rq1.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
